// File: rtl/matrix_add_sub.sv
// Matrix add/subtract engine: two N x N operand registers (A, B) and a result
// register. Writing B starts a row-serial computation (one row per clock);
// the result is presented on dataOut while flag is high (state DONE).
module matrix_add_sub #(
    parameter int ELEM_W = 16,
    parameter int N      = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [N*N*ELEM_W-1:0]   dataIn,
    input  logic                    EN,
    input  logic                    RW,
    input  logic                    matDecide,
    input  logic                    add1sub0,
    output logic [N*N*ELEM_W-1:0]   dataOut,
    output logic                    flag
);

    localparam int BUS_W = N * N * ELEM_W;
    localparam int ROW_W = N * ELEM_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   rowCnt;
    logic [BUS_W-1:0]   matA;
    logic [BUS_W-1:0]   matB;
    logic [BUS_W-1:0]   result;
    logic               opAdd;
    logic               writeA;
    logic               writeB;
    logic [ROW_W-1:0]   rowVal;

    // Per-element modulo-2^ELEM_W add or subtract; no carry crosses elements.
    function automatic logic [ELEM_W-1:0] elemOp(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic              doAdd
    );
        if (doAdd) begin
            elemOp = a + b;
        end else begin
            elemOp = a - b;
        end
    endfunction

    // State register; reset aborts any computation immediately.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Command decode and next state; commands are only honoured in IDLE/DONE.
    always_comb begin
        writeA    = 1'b0;
        writeB    = 1'b0;
        stateNext = state;
        case (state)
            IDLE: begin
                if (EN && !RW) begin
                    if (matDecide) begin
                        writeB    = 1'b1;
                        stateNext = COMPUTE;
                    end else begin
                        writeA    = 1'b1;
                        stateNext = IDLE;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            COMPUTE: begin
                if (rowCnt == CNT_W'(N - 1)) begin
                    stateNext = DONE;
                end else begin
                    stateNext = COMPUTE;
                end
            end
            DONE: begin
                if (EN) begin
                    if (RW) begin
                        stateNext = IDLE;
                    end else if (matDecide) begin
                        writeB    = 1'b1;
                        stateNext = COMPUTE;
                    end else begin
                        writeA    = 1'b1;
                        stateNext = IDLE;
                    end
                end else begin
                    stateNext = DONE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Combinational value of the row currently addressed by rowCnt.
    always_comb begin
        rowVal = {ROW_W{1'b0}};
        for (int c = 0; c < N; c++) begin
            rowVal[c*ELEM_W +: ELEM_W] = elemOp(
                matA[(int'(rowCnt) * N + c) * ELEM_W +: ELEM_W],
                matB[(int'(rowCnt) * N + c) * ELEM_W +: ELEM_W],
                opAdd);
        end
    end

    // Operand, operation, row counter and result registers.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            matA   <= {BUS_W{1'b0}};
            matB   <= {BUS_W{1'b0}};
            result <= {BUS_W{1'b0}};
            opAdd  <= 1'b1;
            rowCnt <= {CNT_W{1'b0}};
        end else begin
            if (writeA) begin
                matA <= dataIn;
            end
            if (writeB) begin
                matB   <= dataIn;
                opAdd  <= add1sub0;
                rowCnt <= {CNT_W{1'b0}};
            end else if (state == COMPUTE) begin
                result[int'(rowCnt) * ROW_W +: ROW_W] <= rowVal;
                if (rowCnt == CNT_W'(N - 1)) begin
                    rowCnt <= {CNT_W{1'b0}};
                end else begin
                    rowCnt <= rowCnt + CNT_W'(1);
                end
            end
        end
    end

    // Result is only visible while valid; otherwise the bus is held at zero.
    always_comb begin
        if (state == DONE) begin
            dataOut = result;
            flag    = 1'b1;
        end else begin
            dataOut = {BUS_W{1'b0}};
            flag    = 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_add_sub.sv
// Directed bench for matrix_add_sub: each task covers one scenario and checks
// flag / dataOut against hand-computed matrices.
module tb_matrix_add_sub;

    logic         clk;
    logic         RESET;
    logic [255:0] dataIn;
    logic         EN;
    logic         RW;
    logic         matDecide;
    logic         add1sub0;
    logic [255:0] dataOut;
    logic         flag;

    int testsRun    = 0;
    int testsFailed = 0;

    matrix_add_sub #(.ELEM_W(16), .N(4)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .dataIn    (dataIn),
        .EN        (EN),
        .RW        (RW),
        .matDecide (matDecide),
        .add1sub0  (add1sub0),
        .dataOut   (dataOut),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix with every element equal to v.
    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] m;
        for (int i = 0; i < 16; i++) m[i*16 +: 16] = v;
        return m;
    endfunction

    // Copy of m with element (r,c) replaced by v.
    function automatic logic [255:0] setEl(input logic [255:0] m, input int r, input int c, input logic [15:0] v);
        logic [255:0] t;
        t = m;
        t[(4*r + c)*16 +: 16] = v;
        return t;
    endfunction

    // Present one command across a single rising edge, then drop EN.
    task automatic cmd(input logic rw, input logic md, input logic op, input logic [255:0] d);
        EN = 1'b1; RW = rw; matDecide = md; add1sub0 = op; dataIn = d;
        @(posedge clk); #1;
        EN = 1'b0; RW = 1'b0; matDecide = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        RESET = 1'b1; EN = 1'b0; RW = 1'b0; matDecide = 1'b0; add1sub0 = 1'b1; dataIn = '0;
        #1;
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL reset_async: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
        tick(2);
        RESET = 1'b0;
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL reset_state: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
        cmd(1'b1, 1'b0, 1'b1, fill(16'h0000));
        tick(4);
        testsRun++;
        if (flag !== 1'b0) begin testsFailed++; $display("FAIL read_in_idle: flag=%b expected 0", flag); end
    endtask

    task automatic test_add;
        logic expFlag;
        cmd(1'b0, 1'b0, 1'b1, fill(16'h0003));
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0002));
        testsRun++;
        if (flag !== 1'b0) begin testsFailed++; $display("FAIL add_flag_e0: flag=%b expected 0", flag); end
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            expFlag = (k == 4);
            testsRun++;
            if (flag !== expFlag) begin testsFailed++; $display("FAIL add_flag_e%0d: flag=%b expected %b", k, flag, expFlag); end
        end
        testsRun++;
        if (dataOut !== fill(16'h0005)) begin testsFailed++; $display("FAIL add_result: dataOut=%h expected %h", dataOut, fill(16'h0005)); end
    endtask

    task automatic test_read_ack;
        EN = 1'b1; RW = 1'b1; matDecide = 1'b0;
        #1;
        testsRun++;
        if (flag !== 1'b1 || dataOut !== fill(16'h0005)) begin testsFailed++; $display("FAIL ack_cycle_data: flag=%b dataOut=%h expected 1/%h", flag, dataOut, fill(16'h0005)); end
        @(posedge clk); #1;
        EN = 1'b0; RW = 1'b0;
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL ack_after: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0001));
        tick(4);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== fill(16'h0004)) begin testsFailed++; $display("FAIL recompute_retained_a: flag=%b dataOut=%h expected 1/%h", flag, dataOut, fill(16'h0004)); end
        cmd(1'b1, 1'b0, 1'b1, fill(16'h0000));
    endtask

    task automatic test_sub_wrap;
        logic [255:0] expM;
        expM = setEl(fill(16'h0000), 0, 0, 16'hFFFF);
        cmd(1'b0, 1'b0, 1'b0, setEl(fill(16'h0007), 0, 0, 16'h0000));
        cmd(1'b0, 1'b1, 1'b0, setEl(fill(16'h0007), 0, 0, 16'h0001));
        tick(4);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== expM) begin testsFailed++; $display("FAIL sub_wrap: flag=%b dataOut=%h expected 1/%h", flag, dataOut, expM); end
        cmd(1'b0, 1'b0, 1'b1, fill(16'h0010));
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL write_a_in_done: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
    endtask

    task automatic test_overflow;
        logic [255:0] aM;
        logic [255:0] expM;
        aM   = setEl(setEl(fill(16'h0010), 3, 3, 16'hFFFF), 3, 2, 16'h1234);
        expM = setEl(setEl(fill(16'h0011), 3, 3, 16'h0001), 3, 2, 16'h1235);
        cmd(1'b0, 1'b0, 1'b0, aM);
        cmd(1'b0, 1'b1, 1'b1, setEl(fill(16'h0001), 3, 3, 16'h0002));
        tick(4);
        testsRun++;
        if (dataOut[255:240] !== 16'h0001) begin testsFailed++; $display("FAIL overflow_33: got %h expected 0001", dataOut[255:240]); end
        testsRun++;
        if (dataOut[239:224] !== 16'h1235) begin testsFailed++; $display("FAIL overflow_32: got %h expected 1235", dataOut[239:224]); end
        testsRun++;
        if (dataOut !== expM) begin testsFailed++; $display("FAIL overflow_all: dataOut=%h expected %h", dataOut, expM); end
        // B rewrite in DONE restarts with the current A, now subtracting.
        cmd(1'b0, 1'b1, 1'b0, fill(16'h0001));
        testsRun++;
        if (flag !== 1'b0) begin testsFailed++; $display("FAIL restart_flag: flag=%b expected 0", flag); end
        tick(4);
        expM = setEl(setEl(fill(16'h000F), 3, 3, 16'hFFFE), 3, 2, 16'h1233);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== expM) begin testsFailed++; $display("FAIL restart_sub: flag=%b dataOut=%h expected 1/%h", flag, dataOut, expM); end
        cmd(1'b1, 1'b0, 1'b1, fill(16'h0000));
    endtask

    task automatic test_cmd_during_compute;
        cmd(1'b0, 1'b0, 1'b1, fill(16'h0002));
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0001));          // E0
        cmd(1'b1, 1'b0, 1'b0, fill(16'h0000));          // E1: read ignored
        cmd(1'b0, 1'b0, 1'b0, fill(16'h1111));          // E2: A write ignored
        testsRun++;
        if (flag !== 1'b0) begin testsFailed++; $display("FAIL busy_flag_e2: flag=%b expected 0", flag); end
        cmd(1'b0, 1'b1, 1'b0, fill(16'h0005));          // E3: B write ignored
        testsRun++;
        if (flag !== 1'b0) begin testsFailed++; $display("FAIL busy_flag_e3: flag=%b expected 0", flag); end
        tick(1);                                        // E4
        testsRun++;
        if (flag !== 1'b1 || dataOut !== fill(16'h0003)) begin testsFailed++; $display("FAIL busy_result: flag=%b dataOut=%h expected 1/%h", flag, dataOut, fill(16'h0003)); end
        add1sub0 = 1'b0;
        tick(2);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== fill(16'h0003)) begin testsFailed++; $display("FAIL op_change_no_effect: flag=%b dataOut=%h expected 1/%h", flag, dataOut, fill(16'h0003)); end
        cmd(1'b1, 1'b0, 1'b1, fill(16'h0000));
    endtask

    task automatic test_async_reset_done;
        cmd(1'b0, 1'b0, 1'b1, fill(16'h0003));
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0004));
        tick(4);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== fill(16'h0007)) begin testsFailed++; $display("FAIL pre_reset_done: flag=%b dataOut=%h expected 1/%h", flag, dataOut, fill(16'h0007)); end
        #2 RESET = 1'b1;
        #1;
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL async_reset_done: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
        #1 RESET = 1'b0;
    endtask

    task automatic test_reset_mid;
        cmd(1'b0, 1'b0, 1'b1, fill(16'h0009));
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0001));          // E0
        tick(1);                                        // E1
        RESET = 1'b1;
        #1;
        testsRun++;
        if (flag !== 1'b0 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL reset_mid_async: flag=%b dataOut=%h expected 0/0", flag, dataOut); end
        EN = 1'b1; RW = 1'b0; matDecide = 1'b1; add1sub0 = 1'b1; dataIn = fill(16'h0004);
        @(posedge clk); #1;                             // E2 with RESET high
        RESET = 1'b0; EN = 1'b0; matDecide = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            testsRun++;
            if (flag !== 1'b0) begin testsFailed++; $display("FAIL reset_no_flag cycle %0d: flag=%b expected 0", k, flag); end
        end
        cmd(1'b0, 1'b1, 1'b1, fill(16'h0000));
        tick(4);
        testsRun++;
        if (flag !== 1'b1 || dataOut !== 256'd0) begin testsFailed++; $display("FAIL reset_a_zero: flag=%b dataOut=%h expected 1/0", flag, dataOut); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_read_ack();
        test_sub_wrap();
        test_overflow();
        test_cmd_during_compute();
        test_async_reset_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
